// File: rtl/pc_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and instruction field helpers for the
// PC fetch/issue controller.
package pc_ctrl_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_BR   = 4'h1;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'h2;
  localparam logic [OPC_W-1:0] OP_JR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'h4;
  localparam logic [OPC_W-1:0] OP_LNK  = 4'h5;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Instruction layout: {opcode, reg field R, displacement D}, MSB first.
  function automatic int opc_lsb(input int bitsize);
    return bitsize - OPC_W;
  endfunction

  function automatic int reg_lsb(input int dispsize);
    return dispsize;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Instruction-memory handshake plus the one-cycle control bundle sent to the PC.
interface pc_seq_ctrl_if #(
  parameter int BITSIZE  = 16,
  parameter int ADDSIZE  = 4,
  parameter int DISPSIZE = 8
);
  logic                imem_req;
  logic                imem_ack;
  logic [BITSIZE-1:0]  imem_data;
  logic                pc_clken;
  logic                pc_branch;
  logic                pc_jmp;
  logic                pc_wren;
  logic [ADDSIZE-1:0]  pc_ra;
  logic [ADDSIZE-1:0]  pc_rw;
  logic [DISPSIZE-1:0] pc_disp;

  modport master (
    output imem_req, pc_clken, pc_branch, pc_jmp, pc_wren, pc_ra, pc_rw, pc_disp,
    input  imem_ack, imem_data
  );

  modport slave (
    input  imem_req, pc_clken, pc_branch, pc_jmp, pc_wren, pc_ra, pc_rw, pc_disp,
    output imem_ack, imem_data
  );
endinterface

// File: rtl/pc_ctrl_decode.sv
// Combinational decode of a latched instruction into the PC control bundle.
// Outputs are ungated; the sequencer qualifies them with its EXEC state.
module pc_ctrl_decode
  import pc_ctrl_pkg::*;
#(
  parameter int                  BITSIZE  = 16,
  parameter int                  ADDSIZE  = 4,
  parameter int                  DISPSIZE = 8,
  parameter logic [ADDSIZE-1:0]  LINKREG  = 4'b1111
) (
  input  logic [BITSIZE-1:0]  instr,
  input  logic                zero,
  output logic                clken,
  output logic                branch,
  output logic                jmp,
  output logic                wren,
  output logic [ADDSIZE-1:0]  ra,
  output logic [ADDSIZE-1:0]  rw,
  output logic [DISPSIZE-1:0] disp,
  output logic                is_halt
);

  localparam int OPC_LSB = opc_lsb(BITSIZE);
  localparam int REG_LSB = reg_lsb(DISPSIZE);

  logic [OPC_W-1:0]    opcode;
  logic [ADDSIZE-1:0]  reg_f;
  logic [DISPSIZE-1:0] disp_f;

  assign opcode = instr[OPC_LSB +: OPC_W];
  assign reg_f  = instr[REG_LSB +: ADDSIZE];
  assign disp_f = instr[DISPSIZE-1:0];

  always_comb begin
    clken   = 1'b1;
    branch  = 1'b0;
    jmp     = 1'b0;
    wren    = 1'b0;
    ra      = '0;
    rw      = '0;
    disp    = '0;
    is_halt = 1'b0;
    case (opcode)
      OP_BR: begin
        branch = 1'b1;
        disp   = disp_f;
      end
      OP_BZ: begin
        branch = zero;
        disp   = disp_f;
      end
      OP_JR: begin
        jmp = 1'b1;
        ra  = reg_f;
      end
      OP_JAL: begin
        jmp  = 1'b1;
        ra   = reg_f;
        wren = 1'b1;
        rw   = LINKREG;
      end
      OP_LNK: begin
        wren = 1'b1;
        rw   = reg_f;
      end
      OP_HALT: begin
        clken   = 1'b0;
        is_halt = 1'b1;
      end
      default: ;  // NOP and unassigned opcodes just step the PC
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/issue sequencer: fetches over req/ack, issues one control pulse per
// instruction, with run/halt, fetch timeout and a retired-instruction counter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for run
//   S_FETCH | imem_req high, waiting for ack (bounded by MAX_WAIT)
//   S_EXEC  | one cycle: decoded controls driven to the PC
//   S_HALT  | HALT retired; absorbing until rst
//   S_ERR   | fetch timed out; absorbing until rst
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                  BITSIZE  = 16,
  parameter int                  ADDSIZE  = 4,
  parameter int                  DISPSIZE = 8,
  parameter logic [ADDSIZE-1:0]  LINKREG  = 4'b1111,
  parameter int                  MAX_WAIT = 15,
  parameter int                  CNTSIZE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               zero,
  pc_seq_ctrl_if.master      bus,
  output logic               halted,
  output logic               err,
  output logic [CNTSIZE-1:0] instr_count
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_TC = WCW'(MAX_WAIT);

  state_t             state, state_nxt;
  logic [BITSIZE-1:0] instr_q;
  logic [WCW-1:0]     wait_cnt;

  logic                dec_clken, dec_branch, dec_jmp, dec_wren, dec_is_halt;
  logic [ADDSIZE-1:0]  dec_ra, dec_rw;
  logic [DISPSIZE-1:0] dec_disp;

  pc_ctrl_decode #(
    .BITSIZE  (BITSIZE),
    .ADDSIZE  (ADDSIZE),
    .DISPSIZE (DISPSIZE),
    .LINKREG  (LINKREG)
  ) u_decode (
    .instr   (instr_q),
    .zero    (zero),
    .clken   (dec_clken),
    .branch  (dec_branch),
    .jmp     (dec_jmp),
    .wren    (dec_wren),
    .ra      (dec_ra),
    .rw      (dec_rw),
    .disp    (dec_disp),
    .is_halt (dec_is_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.imem_ack)
        instr_q <= bus.imem_data;
      // Held at zero outside FETCH, so every FETCH entry starts from zero.
      if (state != S_FETCH)
        wait_cnt <= '0;
      else if (!bus.imem_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_EXEC && !dec_is_halt)
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.imem_req  = 1'b0;
    bus.pc_clken  = 1'b0;
    bus.pc_branch = 1'b0;
    bus.pc_jmp    = 1'b0;
    bus.pc_wren   = 1'b0;
    bus.pc_ra     = '0;
    bus.pc_rw     = '0;
    bus.pc_disp   = '0;
    halted        = 1'b0;
    err           = 1'b0;
    case (state)
      S_IDLE: begin
        if (run)
          state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        // An ack in the terminal-count cycle still wins over the timeout.
        if (bus.imem_ack)
          state_nxt = S_EXEC;
        else if (wait_cnt == WAIT_TC)
          state_nxt = S_ERR;
      end
      S_EXEC: begin
        bus.pc_clken  = dec_clken;
        bus.pc_branch = dec_branch;
        bus.pc_jmp    = dec_jmp;
        bus.pc_wren   = dec_wren;
        bus.pc_ra     = dec_ra;
        bus.pc_rw     = dec_rw;
        bus.pc_disp   = dec_disp;
        if (dec_is_halt)
          state_nxt = S_HALT;
        else if (run)
          state_nxt = S_FETCH;
        else
          state_nxt = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  err    = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: scoreboarded control bundles plus a small
// PC/jump-register model driven by the DUT outputs.
module tb_pc_seq_ctrl;

  typedef struct packed {
    logic       clken;
    logic       branch;
    logic       jmp;
    logic       wren;
    logic [3:0] ra;
    logic [3:0] rw;
    logic [7:0] disp;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        zero;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;

  int n_assert = 0;
  int n_fail   = 0;
  int w;

  ctrl_t sb[$];

  logic [15:0] pc_m;
  logic [15:0] regs [16];

  pc_seq_ctrl_if #(.BITSIZE(16), .ADDSIZE(4), .DISPSIZE(8)) bus ();

  pc_seq_ctrl #(
    .BITSIZE  (16),
    .ADDSIZE  (4),
    .DISPSIZE (8),
    .LINKREG  (4'b1111),
    .MAX_WAIT (15),
    .CNTSIZE  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .zero        (zero),
    .bus         (bus),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Reference PC block: PC+1 semantics, branch relative to PC+1.
  always @(posedge clk) begin
    if (rst) begin
      pc_m <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (bus.pc_clken) begin
      if (bus.pc_jmp)
        pc_m <= regs[bus.pc_ra];
      else if (bus.pc_branch)
        pc_m <= pc_m + 16'd1 + {{8{bus.pc_disp[7]}}, bus.pc_disp};
      else
        pc_m <= pc_m + 16'd1;
      if (bus.pc_wren)
        regs[bus.pc_rw] <= pc_m + 16'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctrl_t model(input logic [15:0] instr, input logic z);
    ctrl_t c;
    c = '0;
    c.clken = 1'b1;
    case (instr[15:12])
      4'h1: begin c.branch = 1'b1; c.disp = instr[7:0]; end
      4'h2: begin c.branch = z;    c.disp = instr[7:0]; end
      4'h3: begin c.jmp = 1'b1; c.ra = instr[11:8]; end
      4'h4: begin c.jmp = 1'b1; c.ra = instr[11:8]; c.wren = 1'b1; c.rw = 4'hF; end
      4'h5: begin c.wren = 1'b1; c.rw = instr[11:8]; end
      4'hF: c = '0;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.imem_req, bus.pc_clken, bus.pc_branch, bus.pc_jmp, bus.pc_wren,
            bus.pc_ra, bus.pc_rw, bus.pc_disp, halted, err, instr_count};
  endfunction

  // Wait for a fetch, hold ack off for waitc cycles, then deliver instr and
  // compare the EXEC-cycle bundle. Returns one negedge after EXEC.
  task automatic issue(input logic [15:0] instr, input int waitc, output int waited);
    ctrl_t o;
    ctrl_t e;
    waited = 0;
    while (!bus.imem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.imem_req) begin
      check("fetch_req", {63'd0, bus.imem_req}, 64'd1);
      return;
    end
    repeat (waitc) @(negedge clk);
    bus.imem_ack  = 1'b1;
    bus.imem_data = instr;
    sb.push_back(model(instr, zero));
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    o = '{bus.pc_clken, bus.pc_branch, bus.pc_jmp, bus.pc_wren,
          bus.pc_ra, bus.pc_rw, bus.pc_disp};
    e = sb.pop_front();
    check($sformatf("exec_ctrl_%h", instr), 64'(o), 64'(e));
    check("exec_req_low", {63'd0, bus.imem_req}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", {63'd0, bus.imem_req}, 64'd0);

    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(16'h0000, 0, w);
      check("nop_fetch_gap", 64'(w), (i == 0) ? 64'd1 : 64'd0);
    end
    check("count_5", 64'(instr_count), 64'd5);
    check("pc_after_nops", 64'(pc_m), 64'd5);

    issue(16'h100F, 0, w);
    check("pc_br_fwd", 64'(pc_m), 64'd21);
    issue(16'h10F3, 0, w);
    check("pc_br_back", 64'(pc_m), 64'd9);

    issue(16'h5600, 0, w);
    check("lnk_reg6", 64'(regs[6]), 64'd10);
    for (int i = 0; i < 3; i++) issue(16'h0000, 0, w);
    check("pc_before_jr", 64'(pc_m), 64'd13);
    issue(16'h3600, 0, w);
    check("pc_jr_link", 64'(pc_m), 64'd10);

    issue(16'h4600, 0, w);
    check("pc_jal", 64'(pc_m), 64'd10);
    check("jal_link15", 64'(regs[15]), 64'd11);
    issue(16'h3F00, 0, w);
    check("pc_jr15", 64'(pc_m), 64'd11);

    zero = 1'b0;
    issue(16'h2004, 0, w);
    check("pc_bz_nt", 64'(pc_m), 64'd12);
    zero = 1'b1;
    issue(16'h2004, 0, w);
    check("pc_bz_t", 64'(pc_m), 64'd17);
    zero = 1'b0;

    issue(16'h6ABC, 0, w);
    check("pc_unknown_op", 64'(pc_m), 64'd18);
    check("count_17", 64'(instr_count), 64'd17);

    // Ack arrives in the 16th FETCH cycle: terminal count, but ack wins.
    issue(16'h0000, 15, w);
    check("late_ack_no_err", {63'd0, err}, 64'd0);
    check("count_18", 64'(instr_count), 64'd18);

    // run dropped mid-fetch: fetch and EXEC finish, then IDLE.
    run = 1'b0;
    issue(16'h0000, 2, w);
    check("run_drop_idle", {63'd0, bus.imem_req}, 64'd0);
    repeat (3) @(negedge clk);
    check("run_drop_stay", {63'd0, bus.imem_req}, 64'd0);
    check("count_19", 64'(instr_count), 64'd19);

    // Reset while fetching with an ack pending.
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("fetch_before_rst", {63'd0, bus.imem_req}, 64'd1);
    rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 16'h1055;
    @(negedge clk);
    check("rst_mid_fetch", all_outs(), 64'd0);
    rst = 1'b0; bus.imem_ack = 1'b0; bus.imem_data = '0;

    // Timeout: 16 unacknowledged FETCH cycles.
    @(negedge clk);
    check("to_fetch_start", {63'd0, bus.imem_req}, 64'd1);
    repeat (15) @(negedge clk);
    check("to_cycle16_err", {63'd0, err}, 64'd0);
    check("to_cycle16_req", {63'd0, bus.imem_req}, 64'd1);
    @(negedge clk);
    check("to_err", {63'd0, err}, 64'd1);
    check("to_req_drop", {63'd0, bus.imem_req}, 64'd0);
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("err_sticky_outs", all_outs(), {1'b0, 21'd0, 1'b0, 1'b1, 16'd0});
    bus.imem_ack = 1'b0;

    // HALT freezes the counter and stops fetching.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0000, 0, w);
    issue(16'hF000, 0, w);
    check("halted", {63'd0, halted}, 64'd1);
    repeat (4) @(negedge clk);
    check("halt_outs", all_outs(), {1'b0, 21'd0, 1'b1, 1'b0, 16'd1});
    check("pc_after_halt", 64'(pc_m), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch/issue controller that sequences the parameterised program counter and its jump-register file.
- Requests each instruction from instruction memory over a req/ack handshake, decodes it, and issues a one-cycle control bundle to the PC: clken, branch, jmp, wren, ra, rw, disp.
- Sits between the instruction memory port and the PC block. Also provides run/halt, a fetch timeout with error flag, and a retired-instruction counter.

Parameters:
- BITSIZE, 16, instruction width; must equal 4+ADDSIZE+DISPSIZE.
- ADDSIZE, 4, register address width (ra/rw).
- DISPSIZE, 8, signed branch displacement width.
- LINKREG, 4'b1111, register written by JAL.
- MAX_WAIT, 15, maximum cycles req may stay unacknowledged.
- CNTSIZE, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; start/continue fetching.
- zero  in  1  condition flag for BZ, sampled in the EXEC cycle.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  memory has instruction on imem_data this cycle.
- imem_data  in  BITSIZE  instruction word.
- pc_clken  out  1  PC update enable.
- pc_branch  out  1  PC += sign-extended disp.
- pc_jmp  out  1  PC <= reg[ra].
- pc_wren  out  1  reg[rw] <= PC+1.
- pc_ra  out  ADDSIZE  jump register address.
- pc_rw  out  ADDSIZE  write register address.
- pc_disp  out  DISPSIZE  displacement.
- halted  out  1  HALT executed.
- err  out  1  fetch timeout; sticky.
- instr_count  out  CNTSIZE  retired instructions.

Behaviour:
- Instruction format: [BITSIZE-1:BITSIZE-4] opcode, next ADDSIZE bits reg field R, low DISPSIZE bits D.
- States:
  - IDLE → FETCH when run=1.
  - FETCH: imem_req=1. On ack, latch imem_data into instr_q and go to EXEC. If wait_cnt==MAX_WAIT and no ack, go to ERR.
  - EXEC: exactly one cycle, then FETCH if run=1, else IDLE. If the opcode is HALT, go to HALT instead.
  - HALT and ERR: absorbing; only rst leaves them.
- Reset (rst=1 at an edge, any state including mid-FETCH):
  - State → IDLE; instr_q=0, wait_cnt=0, instr_count=0, err=0, halted=0.
  - All outputs 0. A pending ack during reset is ignored.
- Outputs are Moore, decoded from state and instr_q. All pc_* outputs and imem_req are 0 outside their active state.
- EXEC decode (pc_ra/pc_rw/pc_disp are 0 unless listed):
  - 0 NOP: clken=1.
  - 1 BR: clken=1, branch=1, disp=D.
  - 2 BZ: clken=1, disp=D, branch=zero.
  - 3 JR: clken=1, jmp=1, ra=R.
  - 4 JAL: clken=1, jmp=1, ra=R, wren=1, rw=LINKREG.
  - 5 LNK: clken=1, wren=1, rw=R.
  - F HALT: clken=0, all controls 0.
  - Any other opcode: behaves as NOP.
- Minimum cost is 2 cycles per instruction, when ack arrives in the first FETCH cycle. Each additional wait cycle adds one.
- wait_cnt:
  - Cleared on FETCH entry.
  - Increments each FETCH cycle without ack.
  - Timeout fires when wait_cnt==MAX_WAIT with no ack, i.e. after MAX_WAIT+1 unacked cycles. An ack in that same cycle wins and no error is raised.
- ERR: err=1, imem_req=0, no PC controls.
- HALT: halted=1.
- instr_count:
  - Increments once per EXEC cycle of a non-HALT opcode.
  - Wraps modulo 2^CNTSIZE.
- run dropped during FETCH: the in-flight fetch and its EXEC complete, then IDLE. run has no effect in EXEC beyond selecting the next state.
- Back-to-back JAL to the same register is legal; the controller does no hazard checking.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - opcode constants: OP_NOP, OP_BR, OP_BZ, OP_JR, OP_JAL, OP_LNK, OP_HALT;
  - state encoding: S_IDLE, S_FETCH, S_EXEC, S_HALT, S_ERR;
  - field-slice constants derived from BITSIZE, ADDSIZE and DISPSIZE.
- One natural sub-module, pc_ctrl_decode: combinational, instr_q + zero → control bundle. The FSM gates its output with the EXEC state.

Test Plan:
- Reset then run=1; memory acks immediately with NOP → imem_req high 1 cycle, pc_clken pulses every 2nd cycle, instr_count=5 after 5 instructions.
- BR with D=8'h0F, then BR with D=8'hF3 → single-cycle pc_branch=1 with pc_disp=0x0F, then 0xF3. Connected PC advances by +15, then −13 relative to PC+1 semantics.
- LNK R=6, then JR R=6 after 3 NOPs → pc_wren=1/pc_rw=6 for one cycle; later pc_jmp=1/pc_ra=6; PC returns to the linked value.
- JAL R=6 → pc_jmp=1, pc_ra=6, pc_wren=1, pc_rw=4'hF in the same cycle. A following JR R=15 returns to the JAL address+1.
- BZ D=4 with zero=0, then with zero=1 → pc_clken=1 both times; pc_branch=0 the first time, 1 the second.
- Edge cases:
  - Ack withheld 16 cycles (MAX_WAIT=15) → err=1 at the 17th edge, imem_req drops, no further PC controls.
  - Ack on exactly the 16th cycle → no error.
  - HALT → halted=1, instr_count frozen.
  - rst mid-FETCH → all outputs 0 on the next cycle.
